// File: rtl/noc_input_buffer_pkg.sv
// noc_pkg: shared flit encoding, field positions and FSM state type for the
// per-port NoC input buffer.
package noc_pkg;

    // Default flit width.
    localparam int NOC_FLIT_W = 32;

    // Flit id field: the top ID_W bits of every flit.
    localparam int ID_W = 3;

    // Packet length field inside a header flit.
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = 12;

    localparam logic [ID_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [ID_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [ID_W-1:0] FLIT_TAIL   = 3'b100;

    typedef enum logic [1:0] {
        NIB_IDLE = 2'd0,
        NIB_REQ  = 2'd1,
        NIB_FWD  = 2'd2
    } nib_state_t;

    // LSB position of the flit id field for a given flit width.
    function automatic int id_lsb(input int flit_w);
        return flit_w - ID_W;
    endfunction

endpackage

// File: rtl/noc_input_buffer_if.sv
// Link/arbiter/crossbar-side signals of one router input port.
// Optional: NIB_PKT_CHECK_EN adds the err_drop stray-flit pulse.
import noc_pkg::*;

interface noc_input_buffer_if #(
    parameter int FLIT_W = NOC_FLIT_W
);
    // Handshakes: a flit moves on a rising clk edge where its valid and the
    // receiver's ready are both high. Link side: in_valid/!in_full (in_full
    // depends only on the registered fill level). Crossbar side:
    // out_valid/out_ready; out_flit is held stable while out_valid && !out_ready.
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_full;
    logic              grant;
    logic              out_ready;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              req;
    logic [ID_W-1:0]   flit_id;
    logic [LEN_W-1:0]  length;
    nib_state_t        dbg_state;
`ifdef NIB_PKT_CHECK_EN
    logic              err_drop;

    modport master (
        output in_flit, in_valid, grant, out_ready,
        input  in_full, out_flit, out_valid, req, flit_id, length, dbg_state, err_drop
    );
    modport slave (
        input  in_flit, in_valid, grant, out_ready,
        output in_full, out_flit, out_valid, req, flit_id, length, dbg_state, err_drop
    );
`else
    modport master (
        output in_flit, in_valid, grant, out_ready,
        input  in_full, out_flit, out_valid, req, flit_id, length, dbg_state
    );
    modport slave (
        input  in_flit, in_valid, grant, out_ready,
        output in_full, out_flit, out_valid, req, flit_id, length, dbg_state
    );
`endif

endinterface

// File: rtl/noc_input_buffer_flit_fifo.sv
// flit_fifo: synchronous FIFO with a combinational head view. Full/empty come
// from the registered count, so a same-cycle pop never frees a slot for a push.
import noc_pkg::*;

module flit_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = NOC_FLIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and fill level; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Pointer and count registers; reset flushes everything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port router input stage. Buffers link flits, decodes
// the head flit, requests the arbiter and forwards a packet while granted.
// Optional: NIB_PKT_CHECK_EN drops stray body/tail flits seen while idle and
// pulses err_drop; without it such a flit is requested and forwarded normally.
import noc_pkg::*;

module noc_input_buffer #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = NOC_FLIT_W
) (
    input  logic                clk,
    input  logic                rst,
    noc_input_buffer_if.slave   bus
);
    localparam int ID_LSB = id_lsb(FLIT_W);

    logic [FLIT_W-1:0] head;
    logic [ID_W-1:0]   head_id;
    logic              empty, full;
    logic              push, pop, drop, fwd_fire, out_valid;

    nib_state_t        state_q;
    logic              req_q;
    logic [LEN_W-1:0]  length_q;

    flit_fifo #(.DEPTH(DEPTH), .W(FLIT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.in_flit),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head_id   = head[ID_LSB +: ID_W];
    assign push      = bus.in_valid && !full;
    assign out_valid = (state_q == NIB_FWD) && bus.grant && !empty;
    assign fwd_fire  = out_valid && bus.out_ready;
    assign pop       = fwd_fire || drop;

`ifdef NIB_PKT_CHECK_EN
    // A non-header at the head of an idle port is discarded.
    assign drop         = (state_q == NIB_IDLE) && !empty && (head_id != FLIT_HEADER);
    assign bus.err_drop = drop;
`else
    assign drop = 1'b0;
`endif

    assign bus.in_full   = full;
    assign bus.out_flit  = head;
    assign bus.out_valid = out_valid;
    assign bus.req       = req_q;
    assign bus.flit_id   = empty ? '0 : head_id;
    assign bus.length    = length_q;
    assign bus.dbg_state = state_q;

    // Packet FSM: idle -> request -> forward, back to request if the grant
    // lapses mid-packet, back to idle once the tail has been handed over.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NIB_IDLE;
            req_q    <= 1'b0;
            length_q <= '0;
        end else begin
            case (state_q)
                NIB_IDLE: begin
                    if (!empty && !drop) begin
                        if (head_id == FLIT_HEADER) length_q <= head[LEN_LSB +: LEN_W];
                        state_q <= NIB_REQ;
                        req_q   <= 1'b1;
                    end
                end
                NIB_REQ: begin
                    if (bus.grant) state_q <= NIB_FWD;
                end
                NIB_FWD: begin
                    if (fwd_fire && head_id == FLIT_TAIL) begin
                        state_q <= NIB_IDLE;
                        req_q   <= 1'b0;
                    end else if (!bus.grant) begin
                        state_q <= NIB_REQ;
                    end
                end
                default: begin
                    state_q <= NIB_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer with a flit scoreboard.
import noc_pkg::*;

module tb_noc_input_buffer;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    noc_input_buffer_if #(.FLIT_W(W)) bus ();

    noc_input_buffer #(.DEPTH(DEPTH), .FLIT_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    bit           toggle_rdy = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_flit;
    logic [11:0]  last_len;
    logic [11:0]  len;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] hdr(input logic [11:0] l);
        return {FLIT_HEADER, 17'd0, l};
    endfunction

    function automatic logic [W-1:0] body();
        logic [28:0] p;
        p = 29'($urandom);
        return {FLIT_BODY, p};
    endfunction

    function automatic logic [W-1:0] tail();
        logic [28:0] p;
        p = 29'($urandom);
        return {FLIT_TAIL, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_rdy) bus.out_ready = ~bus.out_ready;
    endtask

    task automatic push(input logic [W-1:0] f, input bit accept);
        bus.in_flit  = f;
        bus.in_valid = 1'b1;
        if (accept) exp_q.push_back(f);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", W'(exp_q.size()), W'(0));
    endtask

    // Output monitor: order check against the scoreboard, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.out_valid) check("stall_hold", bus.out_flit, prev_flit);
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) check("out_flit", bus.out_flit, exp_q.pop_front());
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_flit  = bus.out_flit;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_flit   = '0;
        bus.in_valid  = 1'b0;
        bus.grant     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_full", W'(bus.in_full), W'(0));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_req", W'(bus.req), W'(0));
        check("rst_flit_id", W'(bus.flit_id), W'(0));
        check("rst_length", W'(bus.length), W'(0));
`ifdef NIB_PKT_CHECK_EN
        check("rst_err_drop", W'(bus.err_drop), W'(0));
`endif
        rst = 1'b0;
        tick();

        // Basic packet
        bus.out_ready = 1'b1;
        push(hdr(12'd20), 1'b1);
        check("bp_flit_id_e0", W'(bus.flit_id), W'(FLIT_HEADER));
        check("bp_req_e0", W'(bus.req), W'(0));
        push(body(), 1'b1);
        check("bp_req_e1", W'(bus.req), W'(1));
        check("bp_length", W'(bus.length), W'(20));
        check("bp_ov_e1", W'(bus.out_valid), W'(0));
        bus.grant = 1'b1;
        push(tail(), 1'b1);
        check("bp_ov_1", W'(bus.out_valid), W'(1));
        tick();
        check("bp_ov_2", W'(bus.out_valid), W'(1));
        tick();
        check("bp_ov_3", W'(bus.out_valid), W'(1));
        tick();
        check("bp_req_after_tail", W'(bus.req), W'(0));
        check("bp_ov_after_tail", W'(bus.out_valid), W'(0));
        check("bp_flit_id_empty", W'(bus.flit_id), W'(0));
        check("bp_sb_empty", W'(exp_q.size()), W'(0));
        bus.grant = 1'b0;
        tick();

        // Full FIFO
        push(hdr(12'd7), 1'b1);
        push(body(), 1'b1);
        push(body(), 1'b1);
        check("ff_not_full_3", W'(bus.in_full), W'(0));
        push(tail(), 1'b1);
        check("ff_full_4", W'(bus.in_full), W'(1));
        push(hdr(12'd9), 1'b0);
        check("ff_full_5", W'(bus.in_full), W'(1));
        check("ff_req", W'(bus.req), W'(1));
        bus.grant = 1'b1;
        wait_drain(20);
        check("ff_req_done", W'(bus.req), W'(0));
        check("ff_in_full_done", W'(bus.in_full), W'(0));
        check("ff_empty_done", W'(bus.flit_id), W'(0));
        check("ff_length", W'(bus.length), W'(7));
        bus.grant = 1'b0;
        tick();

        // Grant drop mid-packet
        push(hdr(12'd33), 1'b1);
        push(body(), 1'b1);
        push(body(), 1'b1);
        push(body(), 1'b1);
        bus.grant = 1'b1;
        tick();
        check("gd_ov_first", W'(bus.out_valid), W'(1));
        tick();
        tick();
        bus.grant = 1'b0;
        #1;
        check("gd_ov_drop", W'(bus.out_valid), W'(0));
        push(tail(), 1'b1);
        check("gd_req_1", W'(bus.req), W'(1));
        check("gd_ov_1", W'(bus.out_valid), W'(0));
        check("gd_head_body", W'(bus.flit_id), W'(FLIT_BODY));
        tick();
        check("gd_req_2", W'(bus.req), W'(1));
        check("gd_ov_2", W'(bus.out_valid), W'(0));
        tick();
        check("gd_req_3", W'(bus.req), W'(1));
        check("gd_length", W'(bus.length), W'(33));
        bus.grant = 1'b1;
        wait_drain(20);
        check("gd_req_done", W'(bus.req), W'(0));
        bus.grant = 1'b0;
        tick();

        // Backpressure and pointer wrap
        bus.grant     = 1'b1;
        bus.out_ready = 1'b1;
        toggle_rdy    = 1'b1;
        for (int p = 0; p < 10; p++) begin
            len = 12'($urandom_range(1, 4095));
            push(hdr(len), 1'b1);
            push(body(), 1'b1);
            push(tail(), 1'b1);
            wait_drain(40);
            last_len = len;
        end
        toggle_rdy    = 1'b0;
        bus.out_ready = 1'b1;
        bus.grant     = 1'b0;
        tick();
        check("bw_length", W'(bus.length), W'(last_len));
        check("bw_req", W'(bus.req), W'(0));

        // Stray flit into an idle port
`ifdef NIB_PKT_CHECK_EN
        push(body(), 1'b0);
        check("sf_err_drop_1", W'(bus.err_drop), W'(1));
        check("sf_req_1", W'(bus.req), W'(0));
        tick();
        check("sf_err_drop_2", W'(bus.err_drop), W'(0));
        check("sf_empty", W'(bus.flit_id), W'(0));
        check("sf_req_2", W'(bus.req), W'(0));
        tick();
        check("sf_err_drop_3", W'(bus.err_drop), W'(0));
        check("sf_req_3", W'(bus.req), W'(0));
`else
        push(body(), 1'b1);
        check("sf_req_idle", W'(bus.req), W'(0));
        tick();
        check("sf_req_up", W'(bus.req), W'(1));
        check("sf_length_kept", W'(bus.length), W'(last_len));
        bus.grant = 1'b1;
        wait_drain(20);
        check("sf_ov_empty", W'(bus.out_valid), W'(0));
        bus.grant = 1'b0;
`endif

        // Reset mid-packet
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        bus.grant     = 1'b1;
        bus.out_ready = 1'b0;
        push(hdr(12'd5), 1'b1);
        push(body(), 1'b1);
        tick();
        check("rm_fwd_ov", W'(bus.out_valid), W'(1));
        check("rm_fwd_state", W'(bus.dbg_state), W'(NIB_FWD));
        rst = 1'b1;
        tick();
        check("rm_in_full", W'(bus.in_full), W'(0));
        check("rm_out_valid", W'(bus.out_valid), W'(0));
        check("rm_req", W'(bus.req), W'(0));
        check("rm_flit_id", W'(bus.flit_id), W'(0));
        check("rm_length", W'(bus.length), W'(0));
        check("rm_state", W'(bus.dbg_state), W'(NIB_IDLE));
`ifdef NIB_PKT_CHECK_EN
        check("rm_err_drop", W'(bus.err_drop), W'(0));
`endif
        rst = 1'b0;
        exp_q.delete();
        bus.grant     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("rm_empty_after", W'(bus.flit_id), W'(0));
        check("rm_req_after", W'(bus.req), W'(0));
        check("rm_ov_after", W'(bus.out_valid), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_input_buffer.md
# noc_input_buffer

Per-port input stage of the 5-port NoC router, instantiated once per direction (L, N, E, W, S) directly upstream of the router arbiter. It buffers incoming flits in a small FIFO and decodes the head flit. It drives the arbiter's `<P>req`, `<P>flit_id` and `<P>length` inputs, and forwards flits to the crossbar while its grant bit is set.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two and ≥2.
- `FLIT_W`, default 32: flit width. Bits [FLIT_W-1:FLIT_W-3] hold flit_id; header bits [11:0] hold the packet length.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_flit`, input, FLIT_W: incoming flit from the link.
- `in_valid`, input, 1: the incoming flit is valid.
- `in_full`, output, 1: FIFO is full. The write is ignored while this is high.
- `grant`, input, 1: this port's one-hot bit of the arbiter's registered state.
- `out_ready`, input, 1: the crossbar accepts a flit.
- `out_flit`, output, FLIT_W: head flit presented to the crossbar.
- `out_valid`, output, 1: `out_flit` is valid.
- `req`, output, 1: request to the arbiter.
- `flit_id`, output, 3: id of the head flit, or 3'b000 when the FIFO is empty.
- `length`, output, 12: length latched from the most recent header.
- `err_drop`, output, 1: present only with `NIB_PKT_CHECK_EN`. Pulses one cycle for each dropped stray flit.

## Operation
- Flit ids: header 3'b001, body 3'b010, tail 3'b100.
- Write: accepted when `in_valid && !in_full`.
- `in_full`: computed from the registered count only. A pop in the same cycle does not free a slot for that cycle's write.
- Pop: occurs when `out_valid && out_ready`, or on a stray drop.
- A simultaneous push and pop leaves the count unchanged.
- Count range: 0..DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FSM states:
  - **IDLE**: `req`=0.
    - FIFO non-empty and head is a header: latch head bits [11:0] into `length`, go to REQ.
    - FIFO non-empty and head is a non-header: see Configuration.
  - **REQ**: `req`=1, `out_valid`=0. When `grant`=1, go to FWD.
  - **FWD**: `req`=1, `out_valid = grant && !empty`.
    - If the popped flit is a tail, go to IDLE.
    - If `grant` drops mid-packet (arbiter timeout or preemption), go to REQ. Forwarding resumes from the same flit on the next grant.
- `out_flit` always shows the FIFO head. It holds its value while `out_valid && !out_ready`.
- A header following a tail in the FIFO re-enters REQ via IDLE. There is always at least one `req`-low cycle between packets.

## Timing
- Reset values: `in_full`=0, `out_valid`=0, `req`=0, `flit_id`=0, `length`=0, `err_drop`=0. FIFO is empty, state is IDLE.
- `rst` asserted mid-packet flushes all buffered flits. No partial packet is resumed.
- Cycle sequence:
  - Header written at edge E0.
  - `flit_id`=3'b001 is visible after E0.
  - `req`=1 after E1.
- Grant to first flit: `grant` is first high after edge G. `out_valid`=1 after G+1.
- Throughput: one flit per cycle while `grant && out_ready` and the FIFO is non-empty.
- Tail pop at edge T: `req`=0 after T, for at least one cycle.
- `flit_id` and `length` are stable throughout REQ and FWD, except that `flit_id` tracks the current head.

## Configuration
- Macro `NIB_PKT_CHECK_EN`.
- Defined: in IDLE, a body or tail flit at the head is popped without forwarding. `err_drop` pulses that cycle and the FSM stays in IDLE.
- Undefined: a non-header head goes to REQ with `length` unchanged and is forwarded normally. The `err_drop` port is absent.

## Structure
- Package `noc_pkg`:
  - `FLIT_HEADER`, `FLIT_BODY`, `FLIT_TAIL` constants.
  - Default `FLIT_W`.
  - Field-position localparams for flit_id and length.
  - FSM state enum `nib_state_t` (IDLE, REQ, FWD).
- Sub-module `flit_fifo`: a synchronous FIFO with push/pop/full/empty/head outputs. The FSM stays in the top level.

## Test plan
- **Basic packet.** Stimulus: reset; push header (length 12'd20), body, tail on consecutive cycles; hold `grant`=1 from the cycle after `req` rises; hold `out_ready`=1. Required: `flit_id`=3'b001 after E0; `length`=20; `req` high after E1; three flits out back-to-back; `req`=0 after the tail pop.
- **Full FIFO.** Stimulus: DEPTH=4; push 5 flits with `grant`=0. Required: `in_full`=1 after the 4th push; the 5th is ignored; count stays 4.
- **Grant drop.** Stimulus: header plus 3 bodies plus tail; drop `grant` after 2 flits; re-grant 3 cycles later. Required: `out_valid`=0 while ungranted; `req` stays 1; the remaining flits follow in order with none lost or duplicated.
- **Backpressure and wrap.** Stimulus: `out_ready` toggles 1/0 for 10 packets of 3 flits. Required: flits match the push order across pointer wrap; `out_flit` is stable while stalled.
- **Stray flit.** Stimulus: push a body flit (3'b010) into an IDLE port. Required, with `NIB_PKT_CHECK_EN`: `err_drop` pulses once; FIFO empty; `req` stays 0. Required, without it: `req`=1 and the flit is forwarded on grant.
- **Reset mid-packet.** Stimulus: assert `rst` one cycle during FWD with 2 flits buffered. Required: after the reset edge, all outputs are 0 and the FIFO is empty.
